// File: rtl/ksa_pkg.sv
// Shared types and widths for the shared 24-bit adder block.
package ksa_pkg;

  localparam int KSA_W = 24;

  typedef struct packed {
    logic [KSA_W-1:0] a;
    logic [KSA_W-1:0] b;
    logic             cin;
  } ksa_op_t;

  typedef struct packed {
    logic [KSA_W-1:0] sum;
    logic             carry;
  } ksa_rsp_t;

endpackage

// File: rtl/ksa_top.sv
// 24-bit Kogge-Stone parallel-prefix adder with carry-in, purely combinational.
module ksa_top
  import ksa_pkg::*;
(
  input  logic [KSA_W-1:0] i_a,
  input  logic [KSA_W-1:0] i_b,
  input  logic             i_cin,
  output logic [KSA_W-1:0] o_sum,
  output logic             o_carry
);

  localparam int LV = $clog2(KSA_W);

  logic [LV:0][KSA_W-1:0] g_lv;
  logic [LV:0][KSA_W-1:0] p_lv;
  logic [KSA_W:0]         c;

  // Prefix tree: level l combines spans at distance 2**l, then carries fold in cin.
  always_comb begin
    g_lv    = '0;
    p_lv    = '0;
    c       = '0;
    g_lv[0] = i_a & i_b;
    p_lv[0] = i_a ^ i_b;
    for (int l = 0; l < LV; l++) begin
      for (int i = 0; i < KSA_W; i++) begin
        if (i >= (1 << l)) begin
          g_lv[l+1][i] = g_lv[l][i] | (p_lv[l][i] & g_lv[l][i-(1<<l)]);
          p_lv[l+1][i] = p_lv[l][i] & p_lv[l][i-(1<<l)];
        end else begin
          g_lv[l+1][i] = g_lv[l][i];
          p_lv[l+1][i] = p_lv[l][i];
        end
      end
    end
    c[0] = i_cin;
    for (int i = 0; i < KSA_W; i++) begin
      c[i+1] = g_lv[LV][i] | (p_lv[LV][i] & i_cin);
    end
    o_sum   = p_lv[0] ^ c[KSA_W-1:0];
    o_carry = c[KSA_W];
  end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: grants the first valid index at or after the pointer.
module rr_arb #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_adv,
  output logic [NREQ-1:0] o_grant,
  output logic [ID_W-1:0] o_grant_idx
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic            found;
  int              idx;

  // Wrapped upward search from the pointer; first hit wins.
  always_comb begin
    found       = 1'b0;
    idx         = 0;
    o_grant_idx = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && i_req[idx]) begin
        found       = 1'b1;
        o_grant_idx = ID_W'(idx);
      end
    end
    o_grant = found ? (NREQ'(1) << o_grant_idx) : '0;
  end

  // Pointer moves just past the winner on a handshake, wrapping at NREQ-1.
  always_comb begin
    ptr_d = ptr_q;
    if (i_adv) begin
      ptr_d = (o_grant_idx == ID_W'(NREQ-1)) ? '0 : o_grant_idx + ID_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge i_clk) begin
    if (i_rst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ksa_share_arb.sv
// Shares one Kogge-Stone adder among NREQ requesters through a two-stage
// pipeline (operand register, result register) with a tagged response.
module ksa_share_arb
  import ksa_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ*KSA_W-1:0] i_req_a,
  input  logic [NREQ*KSA_W-1:0] i_req_b,
  input  logic [NREQ-1:0]       i_req_cin,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [KSA_W-1:0]      o_rsp_sum,
  output logic                  o_rsp_carry,
  output logic [ID_W-1:0]       o_rsp_id
);

  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] grant_idx;
  logic            rsp_en;
  logic            op_en;
  logic            hs;
  ksa_op_t         sel_op;
  ksa_rsp_t        add_rsp;

  logic            op_v_p0_q,   op_v_p0_d;
  ksa_op_t         op_p0_q,     op_p0_d;
  logic [ID_W-1:0] op_id_p0_q,  op_id_p0_d;
  logic            rsp_v_p1_q,  rsp_v_p1_d;
  ksa_rsp_t        rsp_p1_q,    rsp_p1_d;
  logic [ID_W-1:0] rsp_id_p1_q, rsp_id_p1_d;

  rr_arb #(.NREQ(NREQ)) u_arb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req_valid),
    .i_adv       (hs),
    .o_grant     (grant),
    .o_grant_idx (grant_idx)
  );

  // Stall chain, gated ready and operand mux from the granted requester.
  always_comb begin
    rsp_en      = !rsp_v_p1_q || i_rsp_ready;
    op_en       = !op_v_p0_q || rsp_en;
    o_req_ready = (op_en && !i_rst) ? grant : '0;
    hs          = |(o_req_ready & i_req_valid);
    sel_op.a    = i_req_a[int'(grant_idx)*KSA_W +: KSA_W];
    sel_op.b    = i_req_b[int'(grant_idx)*KSA_W +: KSA_W];
    sel_op.cin  = i_req_cin[grant_idx];
  end

  ksa_top u_ksa (
    .i_a     (op_p0_q.a),
    .i_b     (op_p0_q.b),
    .i_cin   (op_p0_q.cin),
    .o_sum   (add_rsp.sum),
    .o_carry (add_rsp.carry)
  );

  // Next-state for both stages; each holds when its enable is low.
  always_comb begin
    op_v_p0_d   = op_v_p0_q;
    op_p0_d     = op_p0_q;
    op_id_p0_d  = op_id_p0_q;
    rsp_v_p1_d  = rsp_v_p1_q;
    rsp_p1_d    = rsp_p1_q;
    rsp_id_p1_d = rsp_id_p1_q;
    // Stage p0: accepted operands
    if (op_en) begin
      op_v_p0_d = hs;
      if (hs) begin
        op_p0_d    = sel_op;
        op_id_p0_d = grant_idx;
      end
    end
    // Stage p1: adder result awaiting the consumer
    if (rsp_en) begin
      rsp_v_p1_d = op_v_p0_q;
      if (op_v_p0_q) begin
        rsp_p1_d    = add_rsp;
        rsp_id_p1_d = op_id_p0_q;
      end
    end
  end

  // Pipeline registers; operand data needs no reset since op_v gates it.
  always_ff @(posedge i_clk) begin
    op_p0_q    <= op_p0_d;
    op_id_p0_q <= op_id_p0_d;
    if (i_rst) begin
      op_v_p0_q   <= 1'b0;
      rsp_v_p1_q  <= 1'b0;
      rsp_p1_q    <= '0;
      rsp_id_p1_q <= '0;
    end else begin
      op_v_p0_q   <= op_v_p0_d;
      rsp_v_p1_q  <= rsp_v_p1_d;
      rsp_p1_q    <= rsp_p1_d;
      rsp_id_p1_q <= rsp_id_p1_d;
    end
  end

  assign o_rsp_valid = rsp_v_p1_q;
  assign o_rsp_sum   = rsp_p1_q.sum;
  assign o_rsp_carry = rsp_p1_q.carry;
  assign o_rsp_id    = rsp_id_p1_q;

endmodule

// File: doc/ksa_share_arb.md
Name: ksa_share_arb

Overview:
Shares one 24-bit Kogge-Stone adder (ksa_top) between NREQ independent requesters. The block provides round-robin arbitration, per-requester valid/ready handshakes, a two-stage pipeline (operand register, then result register) and a tagged response channel with backpressure. It sits between issuing units (e.g. mantissa/exponent datapaths) and the adder, so those units need no private adder.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8, non-power-of-2 allowed.
- ID_W, $clog2(NREQ), width of the response requester tag (derived; do not override).

Ports:
- i_clk, input, 1, single clock; all state on rising edge.
- i_rst, input, 1, synchronous active-high reset.
- i_req_valid, input, NREQ, per-requester request valid.
- o_req_ready, output, NREQ, per-requester accept; one-hot or zero.
- i_req_a, input, NREQ*24, operand A; requester k occupies bits [24k+23:24k].
- i_req_b, input, NREQ*24, operand B; same packing as i_req_a.
- i_req_cin, input, NREQ, carry-in per requester.
- o_rsp_valid, output, 1, response valid.
- i_rsp_ready, input, 1, response consumer ready.
- o_rsp_sum, output, 24, a + b + cin, low 24 bits.
- o_rsp_carry, output, 1, carry-out of the 24-bit add.
- o_rsp_id, output, ID_W, index of the requester that issued this result.

Behaviour:
- Reset (i_rst high at an edge) gives:
  - op-stage valid = 0, rsp-stage valid = 0, RR pointer = 0.
  - o_rsp_valid = 0; o_rsp_sum, o_rsp_carry, o_rsp_id = 0.
  - o_req_ready = 0 while i_rst is high.
- Handshake: a transfer occurs on an edge where valid & ready are both high.
  - Requesters must not make valid depend on ready.
  - Once asserted, a request holds valid and its operands stable until accepted.
- Stage enables:
  - rsp_en = !rsp_v | i_rsp_ready
  - op_en = !op_v | rsp_en
- Arbitration (combinational):
  - Among asserted i_req_valid, grant the first index at or after the RR pointer, searching upward with wrap modulo NREQ.
  - o_req_ready[g] = op_en & grant[g]; all other ready bits are 0.
  - No valid requests: all ready bits are 0.
- Pointer update:
  - On a request handshake by requester g, the pointer becomes (g+1) mod NREQ. For NREQ=3, g=2 wraps the pointer to 0.
  - The pointer holds when there is no handshake.
  - Fairness guarantee: a continuously-valid requester is accepted within NREQ request handshakes.
- Op stage, on an edge with op_en:
  - op_v <= any handshake.
  - On a handshake, a, b, cin and id are registered from the granted requester.
  - Without op_en, the stage holds.
- Adder: the ksa_top instance is driven purely from op-stage registers (combinational).
- Rsp stage, on an edge with rsp_en:
  - rsp_v <= op_v.
  - If op_v, sum, carry and id are registered from the adder output and op-stage id.
  - Without rsp_en, outputs hold stable, so o_rsp_* do not change while valid & !ready.
- Latency: request accepted at edge k → o_rsp_valid high after edge k+1, two cycles, independent of contention.
- Throughput: one add per cycle while i_rsp_ready stays high.
- Backpressure:
  - With rsp full and i_rsp_ready low, a full op stage stalls; o_req_ready goes all-zero.
  - Max in flight = 2; no result is dropped or duplicated.
- Simultaneous events:
  - Response drain and new request acceptance on the same edge are allowed; the pipeline advances fully.
  - All requesters valid at once: exactly one is granted per cycle.
- Reset mid-operation: in-flight op and rsp entries are discarded with no response; the arbiter restarts at requester 0.
- Arithmetic: {o_rsp_carry, o_rsp_sum} = a + b + cin as a 25-bit result; no saturation.

Decomposition:
- Package ksa_pkg:
  - KSA_W = 24 localparam.
  - typedef ksa_op_t = struct {a, b, cin}.
  - typedef ksa_rsp_t = struct {sum, carry}.
- Sub-module rr_arb:
  - Parameterised NREQ.
  - Inputs: request vector, advance strobe.
  - Outputs: one-hot grant, encoded grant index.
  - Owns the RR pointer, reset to 0.
- ksa_share_arb holds the two pipeline stages and the ksa_top instance.

Test Plan:
- Single request, requester 2: a=0xFFFFFF, b=0x000001, cin=0 → two cycles later o_rsp_valid=1, sum=0x000000, carry=1, id=2.
- Carry-in path, requester 0: a=0x7FFFFF, b=0x000000, cin=1 → sum=0x800000, carry=0, id=0.
- All 4 requesters held valid, i_rsp_ready=1, for 8 cycles → accept order 0,1,2,3,0,1,2,3; one response per cycle with matching ids and correct sums.
- NREQ=3 build, requesters 1 and 2 valid → order 1,2,1,2; after grant to 2 the pointer wraps to 0, and requester 0 raised later is served next.
- Backpressure: stream requests, drop i_rsp_ready for 3 cycles → o_rsp_* held constant, o_req_ready=0 once both stages are full, no loss or duplication after release; the scoreboard matches all results.
- Reset with both stages full → the next cycle has o_rsp_valid=0; the first post-reset grant goes to the lowest valid index ≥ 0; no stale response appears.
